// File: rtl/mem_port_master_pkg.sv
// Shared sizing defaults and grant encoding for the unified memory-port initiator.
// Defaults mirror the core-wide address/data widths and memory map.
package mem_port_master_pkg;

    localparam int unsigned AddrBitsDef = 8;
    localparam int unsigned DataBitsDef = 16;
    localparam int unsigned InstSizeDef = 16;
    localparam int unsigned RomSizeDef  = 64;
    localparam int unsigned MemSizeDef  = 256;

    typedef enum logic {
        GntFetch = 1'b0,
        GntData  = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_port_arb.sv
// Two-requester grant for the memory port: a lone requester wins, contention alternates
// starting with data after reset.
module mem_port_arb
    import mem_port_master_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic f_req_i,
    input  logic d_req_i,
    output logic f_gnt_o,
    output logic d_gnt_o
);

    gnt_e last_q, last_d;

    always_comb begin
        d_gnt_o = en_i & d_req_i & (~f_req_i | (last_q == GntFetch));
        f_gnt_o = en_i & f_req_i & ~d_gnt_o;
        last_d  = last_q;
        if (d_gnt_o) begin
            last_d = GntData;
        end else if (f_gnt_o) begin
            last_d = GntFetch;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= GntFetch;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_master.sv
// Initiator for the shared instruction/data memory port: grants one request at a time,
// drives a single-cycle memory access and returns the captured word with a response pulse.
module mem_port_master
    import mem_port_master_pkg::*;
#(
    parameter int unsigned ADDR_BITS        = AddrBitsDef,
    parameter int unsigned DATA_BITS        = DataBitsDef,
    parameter int unsigned INSTRUCTION_SIZE = InstSizeDef,
    parameter int unsigned MEM_SIZE         = MemSizeDef
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        f_req,
    input  logic [ADDR_BITS-1:0]        f_pc,
    output logic                        f_ready,
    output logic                        f_rsp_valid,
    output logic [INSTRUCTION_SIZE-1:0] f_inst,
    input  logic                        d_req,
    input  logic                        d_we,
    input  logic [ADDR_BITS-1:0]        d_addr,
    input  logic [DATA_BITS-1:0]        d_wdata,
    output logic                        d_ready,
    output logic                        d_rsp_valid,
    output logic [INSTRUCTION_SIZE-1:0] d_rdata,
    output logic                        d_err,
    output logic                        o_mem_cs,
    output logic                        o_mem_we,
    output logic                        o_mem_mm_select,
    output logic [ADDR_BITS-1:0]        o_mem_pc,
    output logic [ADDR_BITS-1:0]        o_mem_addr,
    output logic [DATA_BITS-1:0]        o_mem_wdat,
    input  logic [INSTRUCTION_SIZE-1:0] i_mem_inst,
    input  logic [INSTRUCTION_SIZE-1:0] i_mem_dat,
    input  logic                        i_mem_error
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StCapture = 2'd2
    } state_e;

    localparam logic [ADDR_BITS:0] MemLimit = (ADDR_BITS + 1)'(MEM_SIZE);

    state_e                        state_q;
    logic                          is_data_q;
    logic                          is_store_q;
    logic                          fault_q;
    logic                          mem_cs_q;
    logic                          mem_we_q;
    logic                          mem_sel_q;
    logic [ADDR_BITS-1:0]          mem_pc_q;
    logic [ADDR_BITS-1:0]          mem_addr_q;
    logic [DATA_BITS-1:0]          mem_wdat_q;
    logic                          f_rsp_q;
    logic [INSTRUCTION_SIZE-1:0]   f_inst_q;
    logic                          d_rsp_q;
    logic [INSTRUCTION_SIZE-1:0]   d_rdata_q;
    logic                          d_err_q;

    logic arb_en;
    logic f_gnt;
    logic d_gnt;
    logic addr_fault;

    assign arb_en     = (state_q == StIdle) & ~RESET;
    assign addr_fault = {1'b0, d_addr} >= MemLimit;

    mem_port_arb u_arb (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .en_i    (arb_en),
        .f_req_i (f_req),
        .d_req_i (d_req),
        .f_gnt_o (f_gnt),
        .d_gnt_o (d_gnt)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            is_data_q  <= 1'b0;
            is_store_q <= 1'b0;
            fault_q    <= 1'b0;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_sel_q  <= 1'b0;
            mem_pc_q   <= '0;
            mem_addr_q <= '0;
            mem_wdat_q <= '0;
            f_rsp_q    <= 1'b0;
            f_inst_q   <= '0;
            d_rsp_q    <= 1'b0;
            d_rdata_q  <= '0;
            d_err_q    <= 1'b0;
        end else begin
            f_rsp_q <= 1'b0;
            d_rsp_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (d_gnt) begin
                        is_data_q  <= 1'b1;
                        is_store_q <= d_we;
                        fault_q    <= addr_fault;
                        if (addr_fault) begin
                            // Out-of-range address never reaches the memory.
                            state_q <= StCapture;
                        end else begin
                            mem_cs_q   <= 1'b1;
                            mem_we_q   <= d_we;
                            mem_sel_q  <= 1'b1;
                            mem_addr_q <= d_addr;
                            if (d_we) begin
                                mem_wdat_q <= d_wdata;
                            end
                            state_q <= StIssue;
                        end
                    end else if (f_gnt) begin
                        is_data_q  <= 1'b0;
                        is_store_q <= 1'b0;
                        fault_q    <= 1'b0;
                        mem_cs_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_sel_q  <= 1'b0;
                        mem_pc_q   <= f_pc;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    mem_cs_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= StCapture;
                end
                StCapture: begin
                    state_q <= StIdle;
                    if (fault_q) begin
                        d_rsp_q   <= 1'b1;
                        d_rdata_q <= '0;
                        d_err_q   <= 1'b1;
                    end else if (is_data_q) begin
                        d_rsp_q   <= 1'b1;
                        d_rdata_q <= is_store_q ? '0 : i_mem_dat;
                        d_err_q   <= i_mem_error;
                    end else begin
                        f_rsp_q  <= 1'b1;
                        f_inst_q <= i_mem_inst;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign f_ready         = f_gnt;
    assign d_ready         = d_gnt;
    assign f_rsp_valid     = f_rsp_q;
    assign f_inst          = f_inst_q;
    assign d_rsp_valid     = d_rsp_q;
    assign d_rdata         = d_rdata_q;
    assign d_err           = d_err_q;
    assign o_mem_cs        = mem_cs_q;
    assign o_mem_we        = mem_we_q;
    assign o_mem_mm_select = mem_sel_q;
    assign o_mem_pc        = mem_pc_q;
    assign o_mem_addr      = mem_addr_q;
    assign o_mem_wdat      = mem_wdat_q;

endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master with a 9-bit address so out-of-range data accesses are reachable.
// A synchronous memory model sits on the port; expected results come from a shadow array.
module tb_mem_port_master;
    import mem_port_master_pkg::*;

    localparam int AW = 9;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          f_req;
    logic [AW-1:0] f_pc;
    logic          f_ready;
    logic          f_rsp_valid;
    logic [15:0]   f_inst;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [15:0]   d_wdata;
    logic          d_ready;
    logic          d_rsp_valid;
    logic [15:0]   d_rdata;
    logic          d_err;
    logic          o_mem_cs;
    logic          o_mem_we;
    logic          o_mem_mm_select;
    logic [AW-1:0] o_mem_pc;
    logic [AW-1:0] o_mem_addr;
    logic [15:0]   o_mem_wdat;
    logic [15:0]   mem_inst = 16'h0;
    logic [15:0]   mem_dat  = 16'h0;
    logic          mem_err  = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic last_was_data = 1'b0;
    logic [15:0] shadow [256];
    logic [15:0] mem [256];
    logic mem_inited = 1'b0;

    mem_port_master #(
        .ADDR_BITS        (AW),
        .DATA_BITS        (16),
        .INSTRUCTION_SIZE (16),
        .MEM_SIZE         (256)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .f_req           (f_req),
        .f_pc            (f_pc),
        .f_ready         (f_ready),
        .f_rsp_valid     (f_rsp_valid),
        .f_inst          (f_inst),
        .d_req           (d_req),
        .d_we            (d_we),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_ready         (d_ready),
        .d_rsp_valid     (d_rsp_valid),
        .d_rdata         (d_rdata),
        .d_err           (d_err),
        .o_mem_cs        (o_mem_cs),
        .o_mem_we        (o_mem_we),
        .o_mem_mm_select (o_mem_mm_select),
        .o_mem_pc        (o_mem_pc),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wdat      (o_mem_wdat),
        .i_mem_inst      (mem_inst),
        .i_mem_dat       (mem_dat),
        .i_mem_error     (mem_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] init_word(input int i);
        if (i == 5) return 16'h1234;
        return 16'((i * 40503) ^ 23130);
    endfunction

    function automatic logic mem_bad(input logic [AW-1:0] a, input logic we);
        return (int'(a) >= int'(MemSizeDef)) || (we && (int'(a) < int'(RomSizeDef)));
    endfunction

    // Synchronous memory: latches controls on the rising edge, outputs valid next cycle.
    always @(posedge CLK) begin
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_inited <= 1'b1;
        end else if (o_mem_cs) begin
            if (o_mem_mm_select) begin
                mem_err <= mem_bad(o_mem_addr, o_mem_we);
                mem_dat <= mem_bad(o_mem_addr, o_mem_we) ? 16'h0 : mem[o_mem_addr[7:0]];
                if (o_mem_we && !mem_bad(o_mem_addr, o_mem_we)) mem[o_mem_addr[7:0]] <= o_mem_wdat;
            end else begin
                mem_inst <= mem[o_mem_pc[7:0]];
                mem_err  <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) check("rsp_exclusive", 32'(f_rsp_valid & d_rsp_valid), 32'd0);

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic fetch_txn(input logic [AW-1:0] pc);
        int n;
        step();
        f_req = 1'b1;
        f_pc  = pc;
        #1;
        n = 0;
        while (!f_ready && n < 20) begin step(); n++; end
        check("f_ready", 32'(f_ready), 32'd1);
        check("f_ready_d_idle", 32'(d_ready), 32'd0);
        step();
        f_req = 1'b0;
        last_was_data = 1'b0;
        check("f_issue_cs", 32'(o_mem_cs), 32'd1);
        check("f_issue_we", 32'(o_mem_we), 32'd0);
        check("f_issue_sel", 32'(o_mem_mm_select), 32'd0);
        check("f_issue_pc", 32'(o_mem_pc), 32'(pc));
        step();
        check("f_capture_cs", 32'(o_mem_cs), 32'd0);
        check("f_capture_rsp", 32'(f_rsp_valid), 32'd0);
        step();
        check("f_rsp_valid", 32'(f_rsp_valid), 32'd1);
        check("f_inst", 32'(f_inst), 32'(shadow[pc[7:0]]));
        step();
        check("f_rsp_pulse", 32'(f_rsp_valid), 32'd0);
    endtask

    task automatic data_txn(input logic we, input logic [AW-1:0] addr, input logic [15:0] wd);
        int n;
        logic fault;
        logic [15:0] exp_rd;
        logic exp_err;
        fault = int'(addr) >= int'(MemSizeDef);
        step();
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wd;
        #1;
        n = 0;
        while (!d_ready && n < 20) begin step(); n++; end
        check("d_ready", 32'(d_ready), 32'd1);
        check("d_ready_f_idle", 32'(f_ready), 32'd0);
        step();
        d_req = 1'b0;
        last_was_data = 1'b1;
        if (fault) begin
            exp_rd  = 16'h0;
            exp_err = 1'b1;
        end else if (we) begin
            exp_rd  = 16'h0;
            exp_err = int'(addr) < int'(RomSizeDef);
            if (!exp_err) shadow[addr[7:0]] = wd;
        end else begin
            exp_rd  = shadow[addr[7:0]];
            exp_err = 1'b0;
        end
        if (fault) begin
            check("d_fault_no_cs", 32'(o_mem_cs), 32'd0);
        end else begin
            check("d_issue_cs", 32'(o_mem_cs), 32'd1);
            check("d_issue_we", 32'(o_mem_we), 32'(we));
            check("d_issue_sel", 32'(o_mem_mm_select), 32'd1);
            check("d_issue_addr", 32'(o_mem_addr), 32'(addr));
            if (we) check("d_issue_wdat", 32'(o_mem_wdat), 32'(wd));
            step();
            check("d_capture_cs", 32'(o_mem_cs), 32'd0);
            check("d_capture_rsp", 32'(d_rsp_valid), 32'd0);
        end
        step();
        check("d_rsp_valid", 32'(d_rsp_valid), 32'd1);
        check("d_rdata", 32'(d_rdata), 32'(exp_rd));
        check("d_err", 32'(d_err), 32'(exp_err));
        check("d_rsp_no_f", 32'(f_rsp_valid), 32'd0);
        step();
        check("d_rsp_pulse", 32'(d_rsp_valid), 32'd0);
    endtask

    task automatic contention(input logic [AW-1:0] pc, input logic [AW-1:0] addr);
        int n;
        int prev;
        logic exp_data;
        prev = 0;
        exp_data = !last_was_data;
        step();
        f_req  = 1'b1;
        f_pc   = pc;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = addr;
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(f_ready || d_ready) && n < 20) begin step(); n++; end
            check("arb_grant_data", 32'(d_ready), 32'(exp_data));
            check("arb_grant_fetch", 32'(f_ready), 32'(!exp_data));
            if (g > 0) check("arb_accept_gap", 32'(cyc - prev), 32'd3);
            prev = cyc;
            last_was_data = exp_data;
            exp_data = !exp_data;
            step();
        end
        f_req = 1'b0;
        d_req = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        int n;
        int op;
        RESET   = 1'b1;
        f_req   = 1'b0;
        f_pc    = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        repeat (3) step();
        check("rst_f_ready", 32'(f_ready), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd0);
        check("rst_f_rsp", 32'(f_rsp_valid), 32'd0);
        check("rst_f_inst", 32'(f_inst), 32'd0);
        check("rst_d_rsp", 32'(d_rsp_valid), 32'd0);
        check("rst_d_rdata", 32'(d_rdata), 32'd0);
        check("rst_d_err", 32'(d_err), 32'd0);
        check("rst_cs", 32'(o_mem_cs), 32'd0);
        check("rst_we", 32'(o_mem_we), 32'd0);
        check("rst_sel", 32'(o_mem_mm_select), 32'd0);
        check("rst_pc", 32'(o_mem_pc), 32'd0);
        check("rst_addr", 32'(o_mem_addr), 32'd0);
        check("rst_wdat", 32'(o_mem_wdat), 32'd0);
        RESET = 1'b0;
        last_was_data = 1'b0;

        fetch_txn(9'h005);
        data_txn(1'b1, 9'h080, 16'hBEEF);
        data_txn(1'b0, 9'h080, 16'h0);
        data_txn(1'b1, 9'h010, 16'hCAFE);
        data_txn(1'b0, 9'h010, 16'h0);
        data_txn(1'b0, 9'h100, 16'h0);
        fetch_txn(9'h009);
        contention(9'h00C, 9'h080);

        // Reset while a store is in its issue cycle.
        step();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 9'h090;
        d_wdata = 16'h1357;
        #1;
        n = 0;
        while (!d_ready && n < 20) begin step(); n++; end
        check("rst_mid_accept", 32'(d_ready), 32'd1);
        step();
        d_req = 1'b0;
        check("rst_mid_issue_cs", 32'(o_mem_cs), 32'd1);
        check("rst_mid_issue_we", 32'(o_mem_we), 32'd1);
        RESET = 1'b1;
        #1;
        check("rst_mid_cs_drop", 32'(o_mem_cs), 32'd0);
        check("rst_mid_we_drop", 32'(o_mem_we), 32'd0);
        step();
        step();
        RESET = 1'b0;
        last_was_data = 1'b0;
        repeat (4) begin
            step();
            check("rst_mid_no_rsp", 32'(d_rsp_valid), 32'd0);
        end
        data_txn(1'b0, 9'h090, 16'h0);
        data_txn(1'b1, 9'h090, 16'h1357);
        data_txn(1'b0, 9'h090, 16'h0);

        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 2);
            case (op)
                0: fetch_txn(9'($urandom_range(0, 255)));
                1: data_txn(1'b0, 9'($urandom_range(0, 319)), 16'h0);
                default: data_txn(1'b1, 9'($urandom_range(0, 319)), 16'($urandom));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
